// File: rtl/mult_share_arbiter_if.sv
// Request, shared-multiplier and response signals between client logic and
// mult_share_arbiter. The slave view belongs to the arbiter.
interface mult_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [4*NUM_REQ-1:0] req_a;
    logic [4*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic [3:0]           mul_m;
    logic [3:0]           mul_q;
    logic [7:0]           mul_p;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_product;
    logic                 busy;
    logic [15:0]          op_count;

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_m, mul_q, rsp_valid, rsp_id, rsp_product, busy, op_count
    );

    // Environment side: requesters, response consumer and the external multiplier.
    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_m, mul_q, rsp_valid, rsp_id, rsp_product, busy, op_count
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one external 4x4 multiplier among NUM_REQ
// requesters through an operand stage and a result stage.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input logic                clk,
    input logic                rst,
    mult_share_arbiter_if.slave bus
);
    logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic            s1_valid_reg;
    logic [3:0]      s1_a_reg, s1_b_reg;
    logic [ID_W-1:0] s1_id_reg;
    logic            s2_valid_reg;
    logic [7:0]      s2_product_reg;
    logic [ID_W-1:0] s2_id_reg;
    logic [15:0]     op_count_reg;

    logic            s2_free, s1_free, any_valid, accept, s1_move, rsp_fire;
    logic [ID_W-1:0] grant_idx;

    assign s2_free   = !s2_valid_reg || bus.rsp_ready;
    assign s1_free   = !s1_valid_reg || s2_free;
    assign any_valid = |bus.req_valid;
    assign accept    = any_valid && s1_free && !rst;
    assign s1_move   = s1_valid_reg && s2_free;
    assign rsp_fire  = s2_valid_reg && bus.rsp_ready;

    // Scan from the highest offset down so the last hit is the first valid
    // requester at or after rr_ptr in circular order.
    always_comb begin
        int idx;
        grant_idx = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (bus.req_valid[idx]) begin
                grant_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (accept) begin
            if (int'(grant_idx) == NUM_REQ - 1) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_idx + ID_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign bus.req_ready[gi] = accept && (int'(grant_idx) == gi);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg     <= '0;
            s1_valid_reg   <= 1'b0;
            s1_a_reg       <= '0;
            s1_b_reg       <= '0;
            s1_id_reg      <= '0;
            s2_valid_reg   <= 1'b0;
            s2_product_reg <= '0;
            s2_id_reg      <= '0;
            op_count_reg   <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;

            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_a_reg     <= bus.req_a[4*int'(grant_idx) +: 4];
                s1_b_reg     <= bus.req_b[4*int'(grant_idx) +: 4];
                s1_id_reg    <= grant_idx;
            end else if (s1_move) begin
                s1_valid_reg <= 1'b0;
            end

            // Result stage holds its contents until the consumer takes them.
            if (s1_move) begin
                s2_valid_reg   <= 1'b1;
                s2_product_reg <= bus.mul_p;
                s2_id_reg      <= s1_id_reg;
            end else if (rsp_fire) begin
                s2_valid_reg <= 1'b0;
            end

            if (rsp_fire) begin
                op_count_reg <= op_count_reg + 16'd1;
            end
        end
    end

    assign bus.mul_m       = s1_a_reg;
    assign bus.mul_q       = s1_b_reg;
    assign bus.rsp_valid   = s2_valid_reg;
    assign bus.rsp_id      = s2_id_reg;
    assign bus.rsp_product = s2_product_reg;
    assign bus.busy        = s1_valid_reg || s2_valid_reg;
    assign bus.op_count    = op_count_reg;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: a 4-requester instance and a
// 2-requester instance, each wired to a behavioural multiplier.
module tb_mult_share_arbiter;
    logic clk;
    logic rst;

    mult_share_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus4 ();
    mult_share_arbiter_if #(.NUM_REQ(2), .ID_W(1)) bus2 ();

    mult_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mult_share_arbiter #(.NUM_REQ(2), .ID_W(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus4.mul_p = {4'd0, bus4.mul_m} * {4'd0, bus4.mul_q};
    assign bus2.mul_p = {4'd0, bus2.mul_m} * {4'd0, bus2.mul_q};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] exp_id;
        logic [7:0] exp_product;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [3:0]  rr_a[4];
    logic [3:0]  rr_b[4];
    logic [1:0]  rr_exp_id[5];
    logic [7:0]  rr_exp_prod[5];
    logic [3:0]  rr_exp_ready[5];
    logic [1:0]  alt_exp_ready[4];
    logic [7:0]  alt_exp_prod[4];

    initial begin
        vecs[0] = '{2,  4'd7,  4'd9,  2'd2, 8'd63};
        vecs[1] = '{1,  4'd0,  4'd13, 2'd1, 8'd0};
        vecs[2] = '{0,  4'd5,  4'd3,  2'd0, 8'd15};
        vecs[3] = '{2,  4'd12, 4'd11, 2'd2, 8'd132};
        vecs[4] = '{3,  4'd15, 4'd15, 2'd3, 8'd225};

        rr_a = '{4'd3, 4'd6, 4'd9, 4'd13};
        rr_b = '{4'd4, 4'd7, 4'd10, 4'd2};
        rr_exp_id    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_exp_prod  = '{8'd12, 8'd42, 8'd90, 8'd26, 8'd12};
        rr_exp_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        alt_exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
        alt_exp_prod  = '{8'd16, 8'd81, 8'd16, 8'd81};

        rst = 1'b1;
        bus4.req_valid = '1;
        bus4.req_a = '0;
        bus4.req_b = '0;
        bus4.rsp_ready = 1'b1;
        bus2.req_valid = '1;
        bus2.req_a = '0;
        bus2.req_b = '0;
        bus2.rsp_ready = 1'b1;
        tick();
        tick();
        chk("ready_in_reset", 32'(bus4.req_ready), 32'h0);
        chk("ready2_in_reset", 32'(bus2.req_ready), 32'h0);
        bus4.req_valid = '0;
        bus2.req_valid = '0;
        rst = 1'b0;
        #1;
        chk("reset_rsp_valid", 32'(bus4.rsp_valid), 32'h0);
        chk("reset_busy", 32'(bus4.busy), 32'h0);
        chk("reset_op_count", 32'(bus4.op_count), 32'h0);
        chk("reset_mul_m", 32'(bus4.mul_m), 32'h0);
        chk("reset_mul_q", 32'(bus4.mul_q), 32'h0);
        chk("reset_rsp_id", 32'(bus4.rsp_id), 32'h0);
        chk("reset_rsp_product", 32'(bus4.rsp_product), 32'h0);

        // Single-request vectors, one op in flight at a time.
        for (int v = 0; v < 5; v++) begin
            bus4.req_a = 16'h5A5A;
            bus4.req_b = 16'hA5A5;
            bus4.req_a[4*vecs[v].idx +: 4] = vecs[v].a;
            bus4.req_b[4*vecs[v].idx +: 4] = vecs[v].b;
            bus4.req_valid = 4'(1 << vecs[v].idx);
            #1;
            chk("vec_req_ready", 32'(bus4.req_ready), 32'(1 << vecs[v].idx));
            tick();
            bus4.req_valid = '0;
            #1;
            chk("vec_s1_rsp_valid", 32'(bus4.rsp_valid), 32'h0);
            chk("vec_mul_m", 32'(bus4.mul_m), 32'(vecs[v].a));
            chk("vec_mul_q", 32'(bus4.mul_q), 32'(vecs[v].b));
            chk("vec_busy", 32'(bus4.busy), 32'h1);
            tick();
            chk("vec_rsp_valid", 32'(bus4.rsp_valid), 32'h1);
            chk("vec_rsp_id", 32'(bus4.rsp_id), 32'(vecs[v].exp_id));
            chk("vec_rsp_product", 32'(bus4.rsp_product), 32'(vecs[v].exp_product));
            tick();
            chk("vec_op_count", 32'(bus4.op_count), 32'(v + 1));
            chk("vec_idle", 32'(bus4.busy), 32'h0);
            $display("txn vec %0d: req %0d a=%0d b=%0d -> id=%0d product=%0d", v,
                     vecs[v].idx, vecs[v].a, vecs[v].b, bus4.rsp_id, bus4.rsp_product);
        end

        // All four requesting continuously: full-throughput round robin.
        for (int i = 0; i < 4; i++) begin
            bus4.req_a[4*i +: 4] = rr_a[i];
            bus4.req_b[4*i +: 4] = rr_b[i];
        end
        for (int c = 0; c < 7; c++) begin
            bus4.req_valid = (c < 5) ? 4'b1111 : 4'b0000;
            #1;
            chk("rr_req_ready", 32'(bus4.req_ready), (c < 5) ? 32'(rr_exp_ready[c]) : 32'h0);
            if (c >= 2) begin
                chk("rr_rsp_valid", 32'(bus4.rsp_valid), 32'h1);
                chk("rr_rsp_id", 32'(bus4.rsp_id), 32'(rr_exp_id[c-2]));
                chk("rr_rsp_product", 32'(bus4.rsp_product), 32'(rr_exp_prod[c-2]));
                $display("txn rr cycle %0d: id=%0d product=%0d", c, bus4.rsp_id, bus4.rsp_product);
            end
            tick();
        end
        chk("rr_op_count", 32'(bus4.op_count), 32'd10);

        // Backpressure: requester 1 streams while the consumer stalls 5 cycles.
        bus4.rsp_ready = 1'b0;
        bus4.req_a[7:4] = 4'd3;
        bus4.req_b[7:4] = 4'd5;
        bus4.req_valid = 4'b0010;
        #1;
        chk("bp_ready_first", 32'(bus4.req_ready), 32'h2);
        tick();
        bus4.req_a[7:4] = 4'd11;
        bus4.req_b[7:4] = 4'd7;
        #1;
        chk("bp_ready_second", 32'(bus4.req_ready), 32'h2);
        tick();
        for (int c = 2; c < 5; c++) begin
            chk("bp_ready_stalled", 32'(bus4.req_ready), 32'h0);
            chk("bp_rsp_valid", 32'(bus4.rsp_valid), 32'h1);
            chk("bp_rsp_id", 32'(bus4.rsp_id), 32'h1);
            chk("bp_rsp_product", 32'(bus4.rsp_product), 32'd15);
            chk("bp_mul_m", 32'(bus4.mul_m), 32'd11);
            tick();
        end
        bus4.req_valid = '0;
        bus4.rsp_ready = 1'b1;
        #1;
        chk("bp_release_product0", 32'(bus4.rsp_product), 32'd15);
        $display("txn bp: id=%0d product=%0d", bus4.rsp_id, bus4.rsp_product);
        tick();
        chk("bp_release_valid1", 32'(bus4.rsp_valid), 32'h1);
        chk("bp_release_id1", 32'(bus4.rsp_id), 32'h1);
        chk("bp_release_product1", 32'(bus4.rsp_product), 32'd77);
        $display("txn bp: id=%0d product=%0d", bus4.rsp_id, bus4.rsp_product);
        tick();
        chk("bp_drained", 32'(bus4.rsp_valid), 32'h0);
        chk("bp_op_count", 32'(bus4.op_count), 32'd12);
        chk("bp_busy", 32'(bus4.busy), 32'h0);

        // Reset with both stages full and rr_ptr parked at 3.
        bus4.rsp_ready = 1'b0;
        bus4.req_a[11:8] = 4'd2;
        bus4.req_b[11:8] = 4'd6;
        bus4.req_valid = 4'b0100;
        tick();
        tick();
        bus4.req_valid = '0;
        #1;
        chk("mid_busy_before", 32'(bus4.busy), 32'h1);
        chk("mid_rsp_valid_before", 32'(bus4.rsp_valid), 32'h1);
        rst = 1'b1;
        bus4.req_valid = 4'b1010;
        #1;
        chk("mid_ready_in_reset", 32'(bus4.req_ready), 32'h0);
        tick();
        rst = 1'b0;
        bus4.req_valid = '0;
        #1;
        chk("mid_rsp_valid", 32'(bus4.rsp_valid), 32'h0);
        chk("mid_busy", 32'(bus4.busy), 32'h0);
        chk("mid_op_count", 32'(bus4.op_count), 32'h0);
        chk("mid_rsp_product", 32'(bus4.rsp_product), 32'h0);
        bus4.rsp_ready = 1'b1;
        bus4.req_a[7:4] = 4'd8;
        bus4.req_b[7:4] = 4'd8;
        bus4.req_valid = 4'b1010;
        #1;
        chk("mid_grant_first", 32'(bus4.req_ready), 32'h2);
        tick();
        bus4.req_valid = '0;
        tick();
        chk("mid_rsp_id", 32'(bus4.rsp_id), 32'h1);
        chk("mid_rsp_product_after", 32'(bus4.rsp_product), 32'd64);
        $display("txn mid: id=%0d product=%0d", bus4.rsp_id, bus4.rsp_product);
        tick();

        // Two-requester instance alternating grants.
        bus2.req_a = {4'd9, 4'd4};
        bus2.req_b = {4'd9, 4'd4};
        for (int c = 0; c < 6; c++) begin
            bus2.req_valid = (c < 4) ? 2'b11 : 2'b00;
            #1;
            chk("alt_req_ready", 32'(bus2.req_ready), (c < 4) ? 32'(alt_exp_ready[c]) : 32'h0);
            if (c >= 2) begin
                chk("alt_rsp_valid", 32'(bus2.rsp_valid), 32'h1);
                chk("alt_rsp_id", 32'(bus2.rsp_id), 32'(c % 2));
                chk("alt_rsp_product", 32'(bus2.rsp_product), 32'(alt_exp_prod[c-2]));
                $display("txn alt cycle %0d: id=%0d product=%0d", c, bus2.rsp_id, bus2.rsp_product);
            end
            tick();
        end
        chk("alt_op_count", 32'(bus2.op_count), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
